buffer_drain: RTL and testbench

Read-side engine for the circular buffer. It pops words from the buffer's `rd`/`empty`/`data_out` port, hides the buffer's one-cycle read latency behind a 2-entry skid register, and presents the words as a valid/ready stream to downstream logic. It sustains one word per cycle while the sink is ready and never over-reads the buffer.

---
 rtl/buffer_drain.sv | 118 +++++++++++
 tb/tb_buffer_drain.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_drain.sv
// Read-side engine: pops a latency-1 buffer into a 2-entry skid, emits valid/ready stream.
// Optional out_last burst marking is enabled by defining BUFFER_DRAIN_LAST_EN.
module buffer_drain #(
    parameter int word_size = 32,
    parameter int burst_len = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 buf_empty,
    input  logic [word_size-1:0] buf_data,
    output logic                 buf_rd,
    output logic [word_size-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic [15:0]          words_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    state_t               state_nx;
    logic [1:0]           occ;
    logic                 infl;
    logic [word_size-1:0] skid0;
    logic [word_size-1:0] skid1;
    logic                 pop;
    logic [2:0]           pend;

    if (burst_len < 1) begin : g_burst_len_check
        $error("buffer_drain: burst_len must be >= 1");
    end

    assign out_valid = (occ != 2'd0);
    assign out_data  = skid0;
    assign pop       = out_valid && out_ready;

    // Words that will be held or arriving after this edge; never exceed skid depth.
    assign pend   = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
    assign buf_rd = !rst && enable && !buf_empty && (pend < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= 2'd0;
            infl  <= 1'b0;
            skid0 <= '0;
            skid1 <= '0;
        end else begin
            infl <= buf_rd;
            occ  <= occ + {1'b0, infl} - {1'b0, pop};
            case ({infl, pop})
                2'b10: begin
                    if (occ == 2'd0) skid0 <= buf_data;
                    else             skid1 <= buf_data;
                end
                2'b01: skid0 <= skid1;
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0 <= buf_data;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= buf_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (enable) state_nx = RUN;
            end
            RUN: begin
                if (!enable) state_nx = (occ != 2'd0 || infl) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (enable)                       state_nx = RUN;
                else if (occ == 2'd0 && !infl)    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst)      words_out <= 16'd0;
        else if (pop) words_out <= words_out + 16'd1;
    end

`ifdef BUFFER_DRAIN_LAST_EN
    localparam int cw = $clog2(burst_len) + 1;
    localparam logic [cw-1:0] last_idx = cw'(burst_len - 1);

    logic [cw-1:0] beat;

    // Burst position survives enable toggles; only reset realigns it.
    always_ff @(posedge clk) begin
        if (rst)      beat <= '0;
        else if (pop) beat <= (beat == last_idx) ? '0 : beat + 1'b1;
    end

    assign out_last = out_valid && (beat == last_idx);
`else
    assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_drain.sv
// Scoreboard bench for buffer_drain against a latency-1 buffer model.
module tb_buffer_drain;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         buf_empty = 1'b1;
    logic [W-1:0] buf_data = '0;
    logic         buf_rd;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic [15:0]  words_out;

    int n_checks = 0;
    int n_errors = 0;
    int n_rd     = 0;
    int n_xfer   = 0;
    int viol     = 0;
    logic rd_seen = 1'b0;

    logic [W-1:0] mem[$];
    logic [W-1:0] exp_q[$];

    buffer_drain #(.word_size(W), .burst_len(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .buf_empty (buf_empty),
        .buf_data  (buf_data),
        .buf_rd    (buf_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem.push_back(base + W'(i));
            exp_q.push_back(base + W'(i));
        end
        buf_empty = (mem.size() == 0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Buffer model: a pop seen this cycle presents its word for the next cycle.
    always @(posedge clk) begin
        #1;
        if (rd_seen && mem.size() > 0) buf_data = mem.pop_front();
        rd_seen = 1'b0;
        buf_empty = (mem.size() == 0);
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic         exp_last;
        if (buf_rd && buf_empty) viol++;
        if (buf_rd) n_rd++;
        rd_seen = buf_rd;
`ifdef BUFFER_DRAIN_LAST_EN
        exp_last = ((n_xfer % 4) == 3);
`else
        exp_last = 1'b0;
`endif
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(out_data), 64'hdead);
            end else if (out_ready) begin
                e = exp_q.pop_front();
                check("xfer_data", 64'(out_data), 64'(e));
                check("xfer_last", 64'(out_last), 64'(exp_last));
                n_xfer++;
            end else begin
                check("hold_data", 64'(out_data), 64'(exp_q[0]));
            end
        end
    end

    initial begin
        int base;
        int cyc;
        int rd0;
        int x0;
        rst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        load(10, 32'h1);

        // Reset with a ready, non-empty buffer: nothing may be read.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_buf_rd", 64'(buf_rd), 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_data", 64'(out_data), 0);
        check("rst_last", 64'(out_last), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_words", 64'(words_out), 0);

        step();
        rst = 1'b0;
        @(negedge clk); #1;
        check("first_rd", 64'(buf_rd), 1);
        @(negedge clk); #1;
        check("lat_t1_valid", 64'(out_valid), 0);
        @(negedge clk); #1;
        check("lat_t2_valid", 64'(out_valid), 1);
        check("lat_t2_data", 64'(out_data), 1);
        base = n_xfer;
        repeat (9) begin
            @(negedge clk); #1;
        end
        check("stream_rate", 64'(n_xfer - base), 9);
        check("stream_total", 64'(n_xfer), 10);
        repeat (3) @(negedge clk);
        #1;
        check("stream_words", 64'(words_out), 10);
        check("stream_rds", 64'(n_rd), 10);

        // Backpressure: only two reads may be outstanding.
        step();
        out_ready = 1'b0;
        rd0 = n_rd;
        load(5, 32'h101);
        repeat (6) @(negedge clk);
        #1;
        check("bp_rds", 64'(n_rd - rd0), 2);
        check("bp_valid", 64'(out_valid), 1);
        check("bp_data", 64'(out_data), 32'h101);
        step();
        out_ready = 1'b1;
        x0 = n_xfer;
        cyc = 0;
        while (n_xfer < x0 + 5 && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("bp_gapfree_cycles", 64'(cyc), 5);
        check("bp_rds_total", 64'(n_rd - rd0), 5);

        // Underflow: exactly as many reads as words held.
        step();
        rd0 = n_rd;
        load(3, 32'h151);
        repeat (8) @(negedge clk);
        #1;
        check("uf_rds", 64'(n_rd - rd0), 3);
        check("uf_valid", 64'(out_valid), 0);
        check("uf_no_rd_empty", 64'(viol), 0);
        check("uf_words", 64'(words_out), 18);

        // Drain: drop enable with one word held and one in flight.
        step();
        enable = 1'b0;
        repeat (2) step();
        check("pre_drain_idle", 64'(busy), 0);
        load(5, 32'h201);
        enable = 1'b1;
        step();
        step();
        enable = 1'b0;
        rd0 = n_rd;
        x0 = n_xfer;
        @(negedge clk); #1;
        check("drain_rd_off", 64'(buf_rd), 0);
        check("drain_busy", 64'(busy), 1);
        check("drain_valid", 64'(out_valid), 1);
        cyc = 0;
        while (busy && cyc < 10) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("drain_idle", 64'(busy), 0);
        check("drain_rds", 64'(n_rd - rd0), 0);
        check("drain_words", 64'(n_xfer - x0), 2);
        check("drain_last_idle", 64'(out_last), 0);

        // Resume: remaining 3 words plus 5 more form two bursts of 4.
        step();
        enable = 1'b1;
        load(5, 32'h301);
        x0 = n_xfer;
        cyc = 0;
        while (n_xfer < x0 + 8 && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("last_xfers", 64'(n_xfer - x0), 8);
        repeat (2) @(negedge clk);
        #1;
        check("final_words", 64'(words_out), 28);
        check("final_empty_sb", 64'(exp_q.size()), 0);
        check("final_valid", 64'(out_valid), 0);
        check("final_no_rd_empty", 64'(viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
